// File: rtl/som_serial_nbit.sv
// Bit-serial N-bit adder: operands are shifted LSB-first through a single
// full-adder cell with a registered carry loop, behind valid/ready handshakes.

module som_comp_1bit (
   input  logic x,
   input  logic y,
   input  logic Cin,
   output logic A,
   output logic Cout
);

   assign A    = x ^ y ^ Cin;
   assign Cout = (x & y) | (Cin & (x ^ y));

endmodule

module som_serial_nbit #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] A,
   output logic             Cout,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] xs, ys;
   logic             c;
   logic [CW-1:0]    cnt;
   logic             fa_A, fa_Cout;
   logic             last;

   som_comp_1bit u_fa (
      .x    (xs[0]),
      .y    (ys[0]),
      .Cin  (c),
      .A    (fa_A),
      .Cout (fa_Cout)
   );

   assign last      = (cnt == CW'(WIDTH - 1));
   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (in_valid)  state_n = RUN;
         RUN:     if (last)      state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default:                state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xs   <= '0;
         ys   <= '0;
         c    <= 1'b0;
         cnt  <= '0;
         A    <= '0;
         Cout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  xs  <= x;
                  ys  <= y;
                  c   <= Cin;
                  cnt <= '0;
                  A   <= '0;
               end
            end
            RUN: begin
               c   <= fa_Cout;
               // sum bits enter at the MSB; the shift form also covers WIDTH=1
               A   <= WIDTH'({fa_A, A} >> 1);
               xs  <= xs >> 1;
               ys  <= ys >> 1;
               cnt <= cnt + 1'b1;
               if (last) Cout <= fa_Cout;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_som_serial_nbit.sv
// Directed and random bench for som_serial_nbit at WIDTH=4, 1 and 8, with a
// scoreboard of expected sums pushed on accept and popped on out_valid.

module tb_som_serial_nbit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [2:0] in_valid, out_ready, cin;
   logic [7:0] x_s [3];
   logic [7:0] y_s [3];
   wire  [2:0] in_ready_w, out_valid_w, busy_w, cout_w;
   wire  [3:0] a4;
   wire  [0:0] a1;
   wire  [7:0] a8;

   int unsigned wd [3] = '{4, 1, 8};
   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         k;
      logic [7:0] a;
      logic       c;
   } exp_t;
   exp_t sb [$];

   som_serial_nbit #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
      .x(x_s[0][3:0]), .y(y_s[0][3:0]), .Cin(cin[0]), .out_valid(out_valid_w[0]),
      .out_ready(out_ready[0]), .A(a4), .Cout(cout_w[0]), .busy(busy_w[0])
   );

   som_serial_nbit #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
      .x(x_s[1][0:0]), .y(y_s[1][0:0]), .Cin(cin[1]), .out_valid(out_valid_w[1]),
      .out_ready(out_ready[1]), .A(a1), .Cout(cout_w[1]), .busy(busy_w[1])
   );

   som_serial_nbit #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
      .x(x_s[2]), .y(y_s[2]), .Cin(cin[2]), .out_valid(out_valid_w[2]),
      .out_ready(out_ready[2]), .A(a8), .Cout(cout_w[2]), .busy(busy_w[2])
   );

   function automatic logic [7:0] get_a(int k);
      case (k)
         0:       return {4'b0, a4};
         1:       return {7'b0, a1};
         default: return a8;
      endcase
   endfunction

   function automatic logic [7:0] mask_of(int unsigned w);
      return 8'((32'd1 << w) - 32'd1);
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(int k, logic [7:0] xv, logic [7:0] yv, logic ci, int hold);
      int          n;
      int          lat;
      bit          busy_ok;
      exp_t        e;
      int unsigned w;
      int unsigned s;
      w = wd[k];
      n = 0;
      while (!in_ready_w[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", 32'(in_ready_w[k]), 32'd1);
      x_s[k]       = xv;
      y_s[k]       = yv;
      cin[k]       = ci;
      in_valid[k]  = 1'b1;
      out_ready[k] = (hold == 0);
      s = 32'(xv & mask_of(w)) + 32'(yv & mask_of(w)) + 32'(ci);
      e.k = k;
      e.a = 8'(s) & mask_of(w);
      e.c = s[w];
      sb.push_back(e);
      @(posedge clk);
      #1;
      // operands and in_valid wiggle during RUN; none of it may matter
      lat     = 0;
      busy_ok = 1'b1;
      do begin
         x_s[k]      = 8'($urandom);
         y_s[k]      = 8'($urandom);
         cin[k]      = 1'($urandom);
         in_valid[k] = 1'($urandom);
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (!out_valid_w[k] && !busy_w[k]) busy_ok = 1'b0;
      end while (!out_valid_w[k] && lat < 40);
      in_valid[k] = 1'b0;
      check("busy_in_run", 32'(busy_ok), 32'd1);
      check("latency", 32'(lat), w);
      check("out_valid", 32'(out_valid_w[k]), 32'd1);
      if (sb.size() > 0) e = sb.pop_front();
      check("sum_A", 32'(get_a(k)), 32'(e.a));
      check("carry_out", 32'(cout_w[k]), 32'(e.c));
      for (int i = 0; i < hold; i++) begin
         x_s[k]      = 8'($urandom);
         y_s[k]      = 8'($urandom);
         in_valid[k] = ~in_valid[k];
         @(posedge clk);
         @(negedge clk);
         check("hold_A", 32'(get_a(k)), 32'(e.a));
         check("hold_Cout", 32'(cout_w[k]), 32'(e.c));
         check("hold_in_ready", 32'(in_ready_w[k]), 32'd0);
         check("hold_out_valid", 32'(out_valid_w[k]), 32'd1);
      end
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("consumed_out_valid", 32'(out_valid_w[k]), 32'd0);
      check("consumed_in_ready", 32'(in_ready_w[k]), 32'd1);
      check("consumed_busy", 32'(busy_w[k]), 32'd0);
   endtask

   initial begin
      bit never_valid;
      rst       = 1'b1;
      in_valid  = '0;
      out_ready = '0;
      cin       = '0;
      for (int k = 0; k < 3; k++) begin
         x_s[k] = '0;
         y_s[k] = '0;
      end

      // reset held for three cycles, checked in the first cycle after release
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("rst_out_valid", 32'(out_valid_w[k]), 32'd0);
         check("rst_busy", 32'(busy_w[k]), 32'd0);
         check("rst_A", 32'(get_a(k)), 32'd0);
         check("rst_Cout", 32'(cout_w[k]), 32'd0);
         check("rst_in_ready", 32'(in_ready_w[k]), 32'd1);
      end

      do_op(0, 8'h0, 8'h1, 1'b0, 0);
      do_op(0, 8'hF, 8'h1, 1'b0, 0);
      do_op(0, 8'hA, 8'h5, 1'b1, 0);
      do_op(0, 8'h3, 8'h4, 1'b1, 0);
      do_op(0, 8'h9, 8'h8, 1'b1, 6);

      // abort an operation with reset sampled on E2
      @(negedge clk);
      x_s[0] = 8'hF;
      y_s[0] = 8'h0;
      cin[0] = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy", 32'(busy_w[0]), 32'd0);
      check("abort_A", 32'(get_a(0)), 32'd0);
      check("abort_Cout", 32'(cout_w[0]), 32'd0);
      check("abort_out_valid", 32'(out_valid_w[0]), 32'd0);
      check("abort_in_ready_rst", 32'(in_ready_w[0]), 32'd0);
      rst = 1'b0;
      never_valid = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (out_valid_w[0]) never_valid = 1'b0;
      end
      check("abort_no_result", 32'(never_valid), 32'd1);
      do_op(0, 8'h7, 8'h9, 1'b0, 0);

      for (int i = 0; i < 200; i++)
         do_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 0);
      for (int i = 0; i < 200; i++)
         do_op(2, 8'($urandom), 8'($urandom), 1'($urandom), 0);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
